// File: rtl/dlx_pkg.sv
// +--------------------------------------------------------------------+
// | dlx_pkg: shared constants for the data-memory MMIO bridge           |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package dlx_pkg;

  // Register offsets inside the MMIO window (addr[3:0])
  localparam logic [3:0] MMIO_TOHOST  = 4'h0;
  localparam logic [3:0] MMIO_CYCLE   = 4'h4;
  localparam logic [3:0] MMIO_CONSOLE = 4'h8;
  localparam logic [3:0] MMIO_STATUS  = 4'hC;

  // STATUS register bit positions
  localparam int STAT_DONE    = 0;
  localparam int STAT_PASS    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_OVF     = 3;

  typedef enum logic [1:0] {
    FMT_BYTE = 2'b00,
    FMT_HALF = 2'b01,
    FMT_WORD = 2'b10
  } data_format_e;

endpackage

`default_nettype wire

// File: rtl/con_fifo.sv
// +--------------------------------------------------------------------+
// | con_fifo: synchronous console byte FIFO, power-of-2 depth           |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module con_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  // Empty reads as zero so the head byte is clean out of reset
  assign dout_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_mmio_bridge.sv
// +--------------------------------------------------------------------+
// | dmem_mmio_bridge: cpu data port to data_memory with an MMIO window  |
// | for tohost exit, cycle counter, console FIFO, status and watchdog.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_mmio_bridge
  import dlx_pkg::*;
#(
  parameter int                NBIT      = 32,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 8'hF0,
  parameter int                CON_DEPTH = 8,
  parameter int                TIMEOUT   = 10000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_en_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [NBIT-1:0]   cpu_din_i,
  input  logic [1:0]        cpu_data_format_i,
  input  logic              cpu_data_sign_i,
  output logic [NBIT-1:0]   cpu_dout_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [NBIT-1:0]   mem_din_o,
  output logic [1:0]        mem_data_format_o,
  output logic              mem_data_sign_o,
  input  logic [NBIT-1:0]   mem_dout_i,
  output logic              con_valid_o,
  output logic [7:0]        con_data_o,
  input  logic              con_ready_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [NBIT-2:0]   exit_code_o
);

  localparam int CNT_W = $clog2(CON_DEPTH) + 1;

  logic              w_hit, w_mmio, w_mmio_wr, w_load;
  logic [3:0]        w_off;
  logic [NBIT-1:0]   w_rd_val;
  logic [3:0]        w_status;
  logic              w_tohost_wr, w_tohost_exit, w_cycle_wr, w_wdog_fire;
  logic              w_con_push, w_con_pop, w_con_full, w_con_empty, w_con_drop;
  logic [CNT_W-1:0]  w_con_count;

  logic              r_sel;
  logic [NBIT-1:0]   r_rdata;
  logic [NBIT-1:0]   r_tohost;
  logic [31:0]       r_cycle;
  logic [31:0]       r_wdog;
  logic              r_done, r_pass, r_timeout, r_ovf;
  logic [NBIT-2:0]   r_exit;

  assign w_hit     = (cpu_addr_i[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
  assign w_mmio    = cpu_en_i & w_hit;
  assign w_mmio_wr = w_mmio & cpu_we_i;
  assign w_load    = cpu_en_i & ~cpu_we_i;
  assign w_off     = cpu_addr_i[3:0];

  // Pass-through is held at zero during reset so data_memory sees nothing
  assign mem_en_o          = rst_ni & cpu_en_i & ~w_hit;
  assign mem_we_o          = rst_ni & cpu_we_i & ~w_mmio;
  assign mem_addr_o        = rst_ni ? cpu_addr_i : '0;
  assign mem_din_o         = rst_ni ? cpu_din_i : '0;
  assign mem_data_format_o = rst_ni ? cpu_data_format_i : '0;
  assign mem_data_sign_o   = rst_ni & cpu_data_sign_i;

  assign cpu_dout_o = !rst_ni ? '0 : (r_sel ? r_rdata : mem_dout_i);

  assign w_status[STAT_DONE]    = r_done;
  assign w_status[STAT_PASS]    = r_pass;
  assign w_status[STAT_TIMEOUT] = r_timeout;
  assign w_status[STAT_OVF]     = r_ovf;

  always_comb begin
    w_rd_val = '0;
    if (w_mmio) begin
      case (w_off)
        MMIO_TOHOST:  w_rd_val = r_tohost;
        MMIO_CYCLE:   w_rd_val = NBIT'(r_cycle);
        MMIO_CONSOLE: w_rd_val = NBIT'(w_con_count);
        MMIO_STATUS:  w_rd_val = NBIT'(w_status);
        default:      w_rd_val = '0;
      endcase
    end
  end

  assign w_tohost_wr   = w_mmio_wr & (w_off == MMIO_TOHOST);
  assign w_tohost_exit = w_tohost_wr & ~r_done & cpu_din_i[0];
  assign w_cycle_wr    = w_mmio_wr & (w_off == MMIO_CYCLE);
  // A program exit in the same cycle as expiry takes priority
  assign w_wdog_fire   = ~r_done & ~w_tohost_exit & (r_wdog == 32'(TIMEOUT - 1));

  assign w_con_push  = w_mmio_wr & (w_off == MMIO_CONSOLE);
  assign w_con_pop   = con_valid_o & con_ready_i;
  assign w_con_drop  = w_con_push & w_con_full & ~w_con_pop;
  assign con_valid_o = ~w_con_empty;

  con_fifo #(
    .DEPTH (CON_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_con_push),
    .pop_i   (w_con_pop),
    .din_i   (cpu_din_i[7:0]),
    .dout_o  (con_data_o),
    .full_o  (w_con_full),
    .empty_o (w_con_empty),
    .count_o (w_con_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel     <= 1'b0;
      r_rdata   <= '0;
      r_tohost  <= '0;
      r_cycle   <= '0;
      r_wdog    <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_ovf     <= 1'b0;
      r_exit    <= '0;
    end else begin
      if (w_load) begin
        r_sel   <= w_mmio;
        r_rdata <= w_rd_val;
      end
      r_cycle <= w_cycle_wr ? '0 : r_cycle + 32'd1;
      if (r_wdog < 32'(TIMEOUT)) r_wdog <= r_wdog + 32'd1;
      if (w_con_drop) r_ovf <= 1'b1;
      if (w_tohost_wr && !r_done) r_tohost <= cpu_din_i;
      if (w_tohost_exit) begin
        r_done <= 1'b1;
        r_pass <= (cpu_din_i[NBIT-1:1] == '0);
        r_exit <= cpu_din_i[NBIT-1:1];
      end else if (w_wdog_fire) begin
        r_done    <= 1'b1;
        r_timeout <= 1'b1;
        r_pass    <= 1'b0;
      end
    end
  end

  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign timeout_o   = r_timeout;
  assign exit_code_o = r_exit;

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio_bridge.sv
// +--------------------------------------------------------------------+
// | tb_dmem_mmio_bridge: vector table, corner sequences and randomized  |
// | traffic against a queue-based reference model.                      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmem_mmio_bridge;

  localparam int TO    = 60;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cpu_en = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_din = '0;
  logic [1:0]  cpu_fmt = '0;
  logic        cpu_sign = 1'b0;
  logic [31:0] cpu_dout;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_fmt;
  logic        mem_sign;
  logic [31:0] mem_dout = '0;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;
  logic        done, pass, timeout;
  logic [30:0] exit_code;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dmem_mmio_bridge #(
    .NBIT(32), .ADDR_W(8), .MMIO_BASE(8'hF0), .CON_DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cpu_en_i(cpu_en), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
    .cpu_data_format_i(cpu_fmt), .cpu_data_sign_i(cpu_sign), .cpu_dout_o(cpu_dout),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_data_format_o(mem_fmt), .mem_data_sign_o(mem_sign), .mem_dout_i(mem_dout),
    .con_valid_o(con_valid), .con_data_o(con_data), .con_ready_i(con_ready),
    .done_o(done), .pass_o(pass), .timeout_o(timeout), .exit_code_o(exit_code)
  );

  // Reference model state
  int          m_edges;
  logic [31:0] m_cycle, m_tohost, m_rdata;
  logic        m_sel, m_done, m_pass, m_to, m_ovf;
  logic [30:0] m_exit;
  logic [7:0]  m_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_edges = 0; m_cycle = 0; m_tohost = 0; m_rdata = 0;
    m_sel = 0; m_done = 0; m_pass = 0; m_to = 0; m_ovf = 0; m_exit = 0;
    m_q.delete();
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] off);
    case (off)
      4'h0:    return m_tohost;
      4'h4:    return m_cycle;
      4'h8:    return 32'(m_q.size());
      4'hC:    return {28'd0, m_ovf, m_to, m_pass, m_done};
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of behaviour, driven by the inputs currently applied
  function automatic void model_edge();
    logic       mmio = cpu_en && (cpu_addr[7:4] == 4'hF);
    logic [3:0] off  = cpu_addr[3:0];
    logic       wr   = mmio && cpu_we;
    logic       pop  = (m_q.size() > 0) && con_ready;
    int         sz   = m_q.size();
    logic       ext  = wr && off == 4'h0 && cpu_din[0] && !m_done;
    if (cpu_en && !cpu_we) begin
      m_sel   = mmio;
      m_rdata = mmio ? model_read(off) : 32'd0;
    end
    m_edges++;
    if (pop) void'(m_q.pop_front());
    if (wr && off == 4'h8) begin
      if (sz < DEPTH || pop) m_q.push_back(cpu_din[7:0]);
      else m_ovf = 1;
    end
    m_cycle = (wr && off == 4'h4) ? 32'd0 : m_cycle + 32'd1;
    if (wr && off == 4'h0 && !m_done) m_tohost = cpu_din;
    if (ext) begin
      m_done = 1; m_pass = (cpu_din[31:1] == 0); m_exit = cpu_din[31:1];
    end else if (!m_done && m_edges == TO) begin
      m_done = 1; m_to = 1; m_pass = 0;
    end
  endfunction

  task automatic check_model(input int cyc);
    logic hit = (cpu_addr[7:4] == 4'hF);
    logic mmio = cpu_en && hit;
    logic qv = (m_q.size() > 0);
    logic [7:0] qd = qv ? m_q[0] : 8'h00;
    check($sformatf("mem_side@%0d", cyc),
          {mem_en, mem_we, mem_addr, mem_din, mem_fmt, mem_sign},
          {cpu_en && !hit, mmio ? 1'b0 : cpu_we, cpu_addr, cpu_din, cpu_fmt, cpu_sign});
    check($sformatf("cpu_dout@%0d", cyc), cpu_dout, m_sel ? m_rdata : mem_dout);
    check($sformatf("console@%0d", cyc), {con_valid, con_valid ? con_data : 8'h00}, {qv, qd});
    check($sformatf("flags@%0d", cyc), {done, pass, timeout, exit_code}, {m_done, m_pass, m_to, m_exit});
  endtask

  // Called at a falling edge; leaves inputs applied and time at fall+1
  task automatic apply(input logic en, input logic we, input logic [7:0] addr,
                       input logic [31:0] din, input logic rdy, input logic [31:0] md);
    cpu_en = en; cpu_we = we; cpu_addr = addr; cpu_din = din; con_ready = rdy; mem_dout = md;
    cpu_fmt = 2'b10; cpu_sign = 1'b0;
    #1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    apply(1'b1, 1'b1, 8'h10, $urandom, 1'b1, $urandom);
    check("reset_mem_side", {mem_en, mem_we, mem_addr, mem_din, mem_fmt, mem_sign}, 64'd0);
    check("reset_outputs", {cpu_dout, con_valid, con_data, done, pass, timeout}, 64'd0);
    check("reset_exit", {33'd0, exit_code}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    apply(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic rand_inputs();
    logic [7:0]  a;
    logic [31:0] d;
    case ($urandom_range(0, 9))
      0, 1:    a = 8'($urandom_range(0, 239));
      2:       a = 8'hF0;
      3:       a = 8'hF4;
      4, 5, 6: a = 8'hF8;
      7:       a = 8'hFC;
      default: a = 8'hF0 | 8'($urandom_range(0, 15));
    endcase
    d = $urandom;
    if (a == 8'hF0) d = ($urandom_range(0, 9) == 0) ? ((32'($urandom_range(0, 3)) << 1) | 32'd1)
                                                    : (d & 32'hFFFF_FFFE);
    cpu_en = ($urandom_range(0, 4) != 0);
    cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = a; cpu_din = d;
    cpu_fmt = 2'($urandom_range(0, 3)); cpu_sign = 1'($urandom_range(0, 1));
    con_ready = ($urandom_range(0, 3) == 0);
    mem_dout = $urandom;
    #1;
  endtask

  typedef struct {
    logic en, we; logic [7:0] addr; logic [31:0] din; logic rdy; logic [31:0] md;
    logic e_en, e_we; logic [31:0] e_dout; logic e_valid; logic [7:0] e_data;
    logic e_done, e_pass;
  } vec_t;

  function automatic vec_t mk(logic en, logic we, logic [7:0] addr, logic [31:0] din, logic rdy,
                              logic [31:0] md, logic e_en, logic e_we, logic [31:0] e_dout,
                              logic e_valid, logic [7:0] e_data, logic e_done, logic e_pass);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.din = din; v.rdy = rdy; v.md = md;
    v.e_en = e_en; v.e_we = e_we; v.e_dout = e_dout; v.e_valid = e_valid; v.e_data = e_data;
    v.e_done = e_done; v.e_pass = e_pass;
    return v;
  endfunction

  vec_t vt[18];

  initial begin
    // Applied one per cycle straight after reset release
    vt[0]  = mk(1, 1, 8'h10, 32'h12345678, 0, 32'h11111111, 1, 1, 32'h11111111, 0, 8'h00, 0, 0);
    vt[1]  = mk(1, 0, 8'h10, 32'h0,        0, 32'h22222222, 1, 0, 32'h22222222, 0, 8'h00, 0, 0);
    vt[2]  = mk(0, 0, 8'h10, 32'h0,        0, 32'h12345678, 0, 0, 32'h12345678, 0, 8'h00, 0, 0);
    vt[3]  = mk(1, 1, 8'hF4, 32'h0,        0, 32'h33333333, 0, 0, 32'h33333333, 0, 8'h00, 0, 0);
    vt[4]  = mk(1, 0, 8'hF4, 32'h0,        0, 32'h44444444, 0, 0, 32'h44444444, 0, 8'h00, 0, 0);
    vt[5]  = mk(1, 0, 8'hF4, 32'h0,        0, 32'h55555555, 0, 0, 32'h0,        0, 8'h00, 0, 0);
    vt[6]  = mk(0, 0, 8'h00, 32'h0,        0, 32'h66666666, 0, 0, 32'h1,        0, 8'h00, 0, 0);
    vt[7]  = mk(1, 1, 8'hF8, 32'h48,       0, 32'h77777777, 0, 0, 32'h1,        0, 8'h00, 0, 0);
    vt[8]  = mk(1, 1, 8'hF8, 32'h69,       0, 32'h0,        0, 0, 32'h1,        1, 8'h48, 0, 0);
    vt[9]  = mk(1, 0, 8'hF8, 32'h0,        0, 32'h0,        0, 0, 32'h1,        1, 8'h48, 0, 0);
    vt[10] = mk(0, 0, 8'h00, 32'h0,        1, 32'h0,        0, 0, 32'h2,        1, 8'h48, 0, 0);
    vt[11] = mk(0, 0, 8'h00, 32'h0,        1, 32'h0,        0, 0, 32'h2,        1, 8'h69, 0, 0);
    vt[12] = mk(0, 0, 8'h00, 32'h0,        0, 32'h0,        0, 0, 32'h2,        0, 8'h00, 0, 0);
    vt[13] = mk(1, 1, 8'hF0, 32'h1,        0, 32'h0,        0, 0, 32'h2,        0, 8'h00, 0, 0);
    vt[14] = mk(1, 1, 8'hF0, 32'h7,        0, 32'h0,        0, 0, 32'h2,        0, 8'h00, 1, 1);
    vt[15] = mk(1, 0, 8'hFC, 32'h0,        0, 32'h0,        0, 0, 32'h2,        0, 8'h00, 1, 1);
    vt[16] = mk(1, 0, 8'hF0, 32'h0,        0, 32'h0,        0, 0, 32'h3,        0, 8'h00, 1, 1);
    vt[17] = mk(0, 0, 8'h00, 32'h0,        0, 32'h0,        0, 0, 32'h1,        0, 8'h00, 1, 1);

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 18; i++) begin
      apply(vt[i].en, vt[i].we, vt[i].addr, vt[i].din, vt[i].rdy, vt[i].md);
      check($sformatf("vec%0d_mem_en_we", i), {mem_en, mem_we}, {vt[i].e_en, vt[i].e_we});
      check($sformatf("vec%0d_dout", i), cpu_dout, vt[i].e_dout);
      check($sformatf("vec%0d_console", i), {con_valid, con_valid ? con_data : 8'h00},
            {vt[i].e_valid, vt[i].e_data});
      check($sformatf("vec%0d_flags", i), {done, pass, timeout, exit_code},
            {vt[i].e_done, vt[i].e_pass, 1'b0, 31'd0});
      step();
    end

    // Cycle counter shortly after release
    do_reset();
    step(); step();
    apply(1, 0, 8'hF4, 0, 0, $urandom);
    check("cycle_load_no_mem", mem_en, 1'b0);
    step();
    apply(0, 0, 8'h00, 0, 0, $urandom);
    check("cycle_after_reset", cpu_dout, 32'd2);

    // Failing exit code
    do_reset();
    apply(1, 1, 8'hF0, 32'h7, 0, $urandom);
    step();
    apply(0, 0, 8'h00, 0, 0, $urandom);
    check("exit_fail", {done, pass, timeout, exit_code}, {1'b1, 1'b0, 1'b0, 31'd3});

    // Nine pushes into an 8-deep FIFO with the consumer stalled
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(1, 1, 8'hF8, 32'h30 + 32'(i), 0, $urandom);
      step();
    end
    apply(1, 0, 8'hFC, 0, 0, $urandom);
    step();
    apply(1, 0, 8'hF8, 0, 0, $urandom);
    check("ovf_status", cpu_dout, 32'h8);
    step();
    apply(0, 0, 8'h00, 0, 0, $urandom);
    check("full_count", cpu_dout, 32'd8);
    for (int i = 0; i < 8; i++) begin
      apply(0, 0, 8'h00, 0, 1, $urandom);
      check($sformatf("drain%0d", i), {con_valid, con_data}, {1'b1, 8'h30 + 8'(i)});
      step();
    end
    apply(0, 0, 8'h00, 0, 0, $urandom);
    check("drained_empty", con_valid, 1'b0);

    // Watchdog expiry timing
    do_reset();
    for (int i = 0; i < TO - 1; i++) step();
    check("wdog_before", {done, timeout}, 2'b00);
    step();
    apply(0, 0, 8'h00, 0, 0, $urandom);
    check("wdog_fire", {done, pass, timeout}, 3'b101);

    // Exit on the expiry cycle beats the watchdog
    do_reset();
    for (int i = 0; i < TO - 1; i++) step();
    apply(1, 1, 8'hF0, 32'h1, 0, $urandom);
    step();
    apply(0, 0, 8'h00, 0, 0, $urandom);
    check("exit_beats_wdog", {done, pass, timeout, exit_code}, {1'b1, 1'b1, 1'b0, 31'd0});

    // Reset with bytes buffered discards them
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 8'hF8, 32'hA0 + 32'(i), 0, $urandom);
      step();
    end
    check("buffered_valid", {con_valid, con_data}, {1'b1, 8'hA0});
    do_reset();
    check("reset_drops_bytes", con_valid, 1'b0);

    // Randomized traffic against the reference model
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 100; c++) begin
        rand_inputs();
        check_model(ep * 100 + c);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
